// File: rtl/rs232_avm_slave.sv
// Avalon-MM polled 8N1 UART: RX FIFO/TX/STATUS registers, one fixed wait state per access.
// Define UART_LOOPBACK_EN to feed the TX bit into the RX synchronizer and hold uart_txd high.
module rs232_avm_slave #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW:0]   P_ONE  = (AW+1)'(1);
  localparam logic [4:0]    A_RX   = 5'd0;
  localparam logic [4:0]    A_TX   = 5'd4;
  localparam logic [4:0]    A_ST   = 5'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  logic          w_req, w_first, r_ack, r_pop_ok;
  logic [31:0]   r_rdata, w_rd_val;
  logic          w_rx_pop, w_st_clr, w_tx_wr, w_tx_load, w_tx_idle;
  logic          r_rx_ovr, r_tx_ovr, r_ferr, w_rx_ovr_set, w_tx_ovr_set;
  logic [7:0]    r_mem [RX_FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          w_fifo_full, w_fifo_empty, w_push;
  logic          w_rx_in, r_rx_s1, r_rx_s2, r_rx_s3;
  uart_st_t      r_rx_st, w_rx_st_n, r_tx_st, w_tx_st_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n, r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n, r_tx_bit, w_tx_bit_n;
  logic [7:0]    r_rx_sh, w_rx_sh_n, r_tx_sh, w_tx_sh_n;
  logic          w_rx_push, w_rx_ferr, r_txd, w_txd_n;
  logic          w_unused;

  assign w_req           = avm_read | avm_write;
  assign w_first         = w_req & ~r_ack;
  assign avm_waitrequest = w_first;
  assign avm_readdata    = r_rdata;

  // Side effects only in the ack cycle; pop only if the head was actually returned.
  assign w_rx_pop  = r_ack & avm_read & (avm_address == A_RX) & r_pop_ok;
  assign w_st_clr  = r_ack & avm_read & (avm_address == A_ST);
  assign w_tx_wr   = r_ack & avm_write & (avm_address == A_TX);
  assign w_tx_idle = (r_tx_st == S_IDLE);
  assign w_tx_load    = w_tx_wr & w_tx_idle;
  assign w_tx_ovr_set = w_tx_wr & ~w_tx_idle;

  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_fifo_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push       = w_rx_push & (~w_fifo_full | w_rx_pop);
  assign w_rx_ovr_set = w_rx_push & w_fifo_full & ~w_rx_pop;

  always_comb begin
    w_rd_val = '0;
    if (avm_read) begin
      case (avm_address)
        A_RX:    w_rd_val = {24'b0, w_fifo_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]]};
        A_ST:    w_rd_val = {21'b0, r_ferr, r_tx_ovr, r_rx_ovr, ~w_fifo_empty, w_tx_idle, 6'b0};
        default: w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_pop_ok <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_tx_ovr <= 1'b0;
      r_ferr   <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_ack <= w_first;
      if (w_first) begin
        r_rdata  <= w_rd_val;
        r_pop_ok <= avm_read & (avm_address == A_RX) & ~w_fifo_empty;
      end
      r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~w_st_clr);
      r_tx_ovr <= w_tx_ovr_set | (r_tx_ovr & ~w_st_clr);
      r_ferr   <= w_rx_ferr    | (r_ferr   & ~w_st_clr);
      if (w_push)   r_wptr <= r_wptr + P_ONE;
      if (w_rx_pop) r_rptr <= r_rptr + P_ONE;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_rx_sh;
  end

`ifdef UART_LOOPBACK_EN
  assign w_rx_in  = r_txd;
  assign uart_txd = 1'b1;
  assign w_unused = ^{avm_writedata[31:8], uart_rxd};
`else
  assign w_rx_in  = uart_rxd;
  assign uart_txd = r_txd;
  assign w_unused = ^avm_writedata[31:8];
`endif

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_s1  <= w_rx_in;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_st  <= w_rx_st_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_sh  <= w_rx_sh_n;
    end
  end

  // r_rx_s3 is the previous synchronized level, used only for falling-edge detect.
  always_comb begin
    w_rx_st_n  = r_rx_st;
    w_rx_cnt_n = r_rx_cnt;
    w_rx_bit_n = r_rx_bit;
    w_rx_sh_n  = r_rx_sh;
    w_rx_push  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        if (r_rx_s3 & ~r_rx_s2) begin
          w_rx_st_n  = S_START;
          w_rx_cnt_n = '0;
        end
      end
      S_START: begin
        if (r_rx_cnt == C_HALF) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          w_rx_st_n  = r_rx_s2 ? S_IDLE : S_DATA;
        end else begin
          w_rx_cnt_n = r_rx_cnt + C_ONE;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_bit_n = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_st_n = S_STOP;
        end else begin
          w_rx_cnt_n = r_rx_cnt + C_ONE;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == C_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_st_n  = S_IDLE;
          w_rx_push  = r_rx_s2;
          w_rx_ferr  = ~r_rx_s2;
        end else begin
          w_rx_cnt_n = r_rx_cnt + C_ONE;
        end
      end
      default: w_rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_tx_st  <= w_tx_st_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_sh  <= w_tx_sh_n;
      r_txd    <= w_txd_n;
    end
  end

  always_comb begin
    w_tx_st_n  = r_tx_st;
    w_tx_cnt_n = r_tx_cnt;
    w_tx_bit_n = r_tx_bit;
    w_tx_sh_n  = r_tx_sh;
    w_txd_n    = r_txd;
    case (r_tx_st)
      S_IDLE: begin
        w_txd_n = 1'b1;
        if (w_tx_load) begin
          w_tx_st_n  = S_START;
          w_tx_cnt_n = '0;
          w_tx_sh_n  = avm_writedata[7:0];
          w_txd_n    = 1'b0;
        end
      end
      S_START: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_st_n  = S_DATA;
          w_tx_cnt_n = '0;
          w_tx_bit_n = '0;
          w_txd_n    = r_tx_sh[0];
        end else begin
          w_tx_cnt_n = r_tx_cnt + C_ONE;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_st_n = S_STOP;
            w_txd_n   = 1'b1;
          end else begin
            w_tx_bit_n = r_tx_bit + 3'd1;
            w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
            w_txd_n    = r_tx_sh[1];
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + C_ONE;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == C_LAST) begin
          w_tx_st_n  = S_IDLE;
          w_tx_cnt_n = '0;
        end else begin
          w_tx_cnt_n = r_tx_cnt + C_ONE;
        end
      end
      default: w_tx_st_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rs232_avm_slave.sv
// Bench for rs232_avm_slave: directed literal checks plus randomized traffic against a frame-level model.
module tb_rs232_avm_slave;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic        rd, wr;
  logic [31:0] rdata, wdata;
  logic        wreq;
  logic        rxd, txd;

  always #5 clk = ~clk;

  rs232_avm_slave #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .avm_clk(clk), .avm_rst(rst), .avm_address(addr), .avm_read(rd),
    .avm_readdata(rdata), .avm_write(wr), .avm_writedata(wdata),
    .avm_waitrequest(wreq), .uart_rxd(rxd), .uart_txd(txd)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: byte queue, sticky flags, and the cycle in which the last TX load was acked.
  logic [7:0] m_q[$];
  bit         m_rx_ovr, m_tx_ovr, m_ferr, m_tx_act;
  int         m_tx_load;
  logic [7:0] m_tx_byte;

  function automatic bit tx_busy(input int c);
    return m_tx_act && (c >= m_tx_load + 1) && (c <= m_tx_load + 10 * CPB);
  endfunction

  function automatic logic tx_bit(input int c);
    int k;
    if (!tx_busy(c)) return 1'b1;
    k = (c - m_tx_load - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_tx_byte[k-1];
  endfunction

  function automatic logic [31:0] m_status(input int c);
    logic [31:0] s;
    s = '0;
    s[6]  = !tx_busy(c);
    s[7]  = (m_q.size() != 0);
    s[8]  = m_rx_ovr;
    s[9]  = m_tx_ovr;
    s[10] = m_ferr;
    return s;
  endfunction

  always @(negedge clk) begin
    check("txd", 32'(txd), 32'(tx_bit(cyc)));
    if (!(rd | wr)) check("wreq_idle", 32'(wreq), 32'd0);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_q.delete();
    m_rx_ovr = 0; m_tx_ovr = 0; m_ferr = 0; m_tx_act = 0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    idle(3);
    rst = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'd0);
  endtask

  task automatic bus_read(input logic [4:0] a, input string nm, output logic [31:0] d);
    logic [31:0] e;
    e = '0;
    if (a == 5'd0 && m_q.size() != 0) e = {24'b0, m_q[0]};
    else if (a == 5'd8) e = m_status(cyc);
    addr = a; rd = 1'b1;
    @(negedge clk);
    check({nm, "_wait1"}, 32'(wreq), 32'd1);
    @(negedge clk);
    check({nm, "_wait0"}, 32'(wreq), 32'd0);
    d = rdata;
    check(nm, rdata, e);
    if (a == 5'd0 && m_q.size() != 0) void'(m_q.pop_front());
    if (a == 5'd8) begin m_rx_ovr = 0; m_tx_ovr = 0; m_ferr = 0; end
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] dd, input logic [23:0] hi, output int n);
    addr = a; wdata = {hi, dd}; wr = 1'b1;
    @(negedge clk);
    check("wr_wait1", 32'(wreq), 32'd1);
    @(negedge clk);
    check("wr_wait0", 32'(wreq), 32'd0);
    n = cyc;
    if (a == 5'd4) begin
      if (!tx_busy(n)) begin m_tx_act = 1; m_tx_load = n; m_tx_byte = dd; end
      else m_tx_ovr = 1;
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stp);
    rxd = 1'b0; idle(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; idle(CPB); end
    rxd = stp; idle(CPB);
    rxd = 1'b1; idle(CPB);
    if (stp) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_rx_ovr = 1;
    end else begin
      m_ferr = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] d;
    int          n, t;
    logic        exp_seq [10];
    logic [4:0]  ign_wr [5];
    logic [4:0]  ign_rd [5];
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ign_wr  = '{5'd0, 5'd8, 5'd12, 5'd1, 5'd31};
    ign_rd  = '{5'd4, 5'd12, 5'd1, 5'd20, 5'd31};
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rxd = 1'b1;
    do_reset();

    bus_read(5'd8, "st_reset", d);
    check("st_reset_lit", d, 32'h40);

    rx_frame(8'hA5, 1'b1);
    bus_read(5'd8, "st_a5", d);   check("st_a5_lit", d, 32'hC0);
    bus_read(5'd0, "rx_a5", d);   check("rx_a5_lit", d, 32'hA5);
    bus_read(5'd8, "st_a5b", d);  check("st_a5b_lit", d, 32'h40);

    bus_write(5'd4, 8'h3C, 24'h0, n);
    for (int k = 0; k < 10; k++) begin
      t = n + 1 + k * CPB + CPB / 2;
      while (cyc < t) begin @(posedge clk); #1; end
      @(negedge clk);
      check("tx3c_bit", 32'(txd), 32'(exp_seq[k]));
      @(posedge clk); #1;
      if (k == 4) begin
        bus_read(5'd8, "st_txbusy", d);
        check("st_txbusy_b6", 32'(d[6]), 32'd0);
      end
    end
    while (cyc <= n + 10 * CPB) begin @(posedge clk); #1; end
    bus_read(5'd8, "st_txdone", d);
    check("st_txdone_lit", d, 32'h40);

    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      bus_read(5'd0, "rx_seq", d);
      check("rx_seq_lit", d, 32'(i));
    end
    bus_read(5'd8, "st_ovr1", d);  check("st_ovr1_b8", 32'(d[8]), 32'd1);
    bus_read(5'd8, "st_ovr2", d);  check("st_ovr2_b8", 32'(d[8]), 32'd0);

    rx_frame(8'h5A, 1'b0);
    bus_read(5'd8, "st_ferr", d);  check("st_ferr_lit", d, 32'h440);
    rxd = 1'b0; idle(3); rxd = 1'b1; idle(4 * CPB);
    bus_read(5'd8, "st_glitch", d); check("st_glitch_lit", d, 32'h40);
    bus_read(5'd0, "rx_glitch", d); check("rx_glitch_lit", d, 32'h0);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0, 1: rx_frame(8'($urandom), 1'($urandom_range(0, 5) != 0));
        2: bus_read(5'd0, "rnd_rx", d);
        3: bus_read(5'd8, "rnd_st", d);
        4: bus_write(5'd4, 8'($urandom), 24'($urandom), n);
        5: bus_write(ign_wr[$urandom_range(0, 4)], 8'($urandom), 24'($urandom), n);
        default: bus_read(ign_rd[$urandom_range(0, 4)], "rnd_unmap", d);
      endcase
      idle($urandom_range(0, 12));
    end
    idle(12 * CPB);

    rx_frame(8'h77, 1'b1);
    bus_write(5'd4, 8'h96, 24'h0, n);
    idle(3 * CPB);
    do_reset();
    bus_read(5'd8, "st_postrst", d); check("st_postrst_lit", d, 32'h40);
    bus_read(5'd0, "rx_postrst", d); check("rx_postrst_lit", d, 32'h0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
